// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the MIPS pipeline, directly upstream of the IF/ID
// register. It owns the program counter and fetches one instruction at a time
// from instruction memory over a variable-latency request/response handshake.
// Each cycle it presents either a real instruction with its PC+4, or a NOP
// bubble (all zeros), to IF/ID.
//
// Parameters
//   RESET_PC     address of the first fetch after reset (bits [1:0] forced 0)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   stall        fetch hold from the hazard unit; nothing is delivered while high
//   redirect     branch/jump taken, resolved downstream
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   imem_req     request valid to instruction memory
//   imem_addr    request address (word aligned)
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  response data valid
//   imem_rdata   response instruction word
//   rd_out       instruction to IF/ID; 0 = bubble
//   newPC_out    PC+4 of the delivered instruction; 0 with a bubble
//   if_valid     rd_out/newPC_out carry a real instruction this cycle
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] rd_out,
    output logic [31:0] newPC_out,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc;        // next fetch address
    logic [31:0] fetch_pc;  // address of the in-flight request
    logic        kill;      // in-flight response belongs to a squashed path
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic [31:0] redirect_aligned;
    logic        unused_redirect_bits;

    assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC_ALIGNED;
            fetch_pc  <= '0;
            kill      <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        fetch_pc <= pc;
                        state    <= WAIT;
                        if (redirect) begin
                            // The accepted request is already stale; squash its response.
                            pc   <= redirect_aligned;
                            kill <= 1'b1;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end else if (redirect) begin
                        pc <= redirect_aligned;
                    end
                end

                WAIT: begin
                    if (imem_rvalid) begin
                        state <= FETCH;
                        if (redirect) begin
                            pc <= redirect_aligned;
                        end
                        if (kill) begin
                            kill <= 1'b0;
                        end else if (!redirect && stall) begin
                            buf_instr <= imem_rdata;
                            buf_pc    <= fetch_pc;
                            state     <= HOLD;
                        end
                    end else if (redirect) begin
                        // Response still pending: it must run out before the new fetch.
                        pc   <= redirect_aligned;
                        kill <= 1'b1;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc        <= redirect_aligned;
                        buf_instr <= '0;
                        buf_pc    <= '0;
                        state     <= FETCH;
                    end else if (!stall) begin
                        state <= FETCH;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: combinational from state and inputs, bubble by default
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        rd_out    = '0;
        newPC_out = '0;
        if_valid  = 1'b0;
        // Reset is asynchronous, so the outputs are forced quiet while it is held.
        if (rst) begin
            case (state)
                FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = pc;
                end
                WAIT: begin
                    if (imem_rvalid && !kill && !redirect && !stall) begin
                        rd_out    = imem_rdata;
                        newPC_out = fetch_pc + 32'd4;
                        if_valid  = 1'b1;
                    end
                end
                HOLD: begin
                    if (!redirect && !stall) begin
                        rd_out    = buf_instr;
                        newPC_out = buf_pc + 32'd4;
                        if_valid  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Testbench for if_fetch_unit. Two instances are built: dut_a with the default
// RESET_PC and dut_b with RESET_PC = 32'hFFFF_FFFC; the unused one is held in
// reset and a select muxes the active one onto the shared memory model.
// A negedge monitor pops an expected {instruction, PC+4} from a scoreboard
// queue whenever if_valid is high, and checks bubbles are all zeros otherwise.
// Memory returns addr ^ 32'hA5A5_0000 after a programmable latency.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        req_a, req_b, valid_a, valid_b;
    logic [31:0] addr_a, addr_b, rd_a, rd_b, npc_a, npc_b;

    logic        sel;
    logic        cur_req, cur_valid;
    logic [31:0] cur_addr, cur_rd, cur_npc;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];

    // memory model state
    int          mem_lat;
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;

    if_fetch_unit dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (req_a),
        .imem_addr  (addr_a),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .rd_out     (rd_a),
        .newPC_out  (npc_a),
        .if_valid   (valid_a)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (req_b),
        .imem_addr  (addr_b),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .rd_out     (rd_b),
        .newPC_out  (npc_b),
        .if_valid   (valid_b)
    );

    assign cur_req   = sel ? req_b   : req_a;
    assign cur_addr  = sel ? addr_b  : addr_a;
    assign cur_rd    = sel ? rd_b    : rd_a;
    assign cur_npc   = sel ? npc_b   : npc_a;
    assign cur_valid = sel ? valid_b : valid_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (cur_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_delivery: got rd=%h npc=%h, none expected", cur_rd, cur_npc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cur_rd !== e.instr) begin
                    n_fail++;
                    $display("FAIL sb_rd_out: got %h, want %h", cur_rd, e.instr);
                end
                n_checks++;
                if (cur_npc !== e.npc) begin
                    n_fail++;
                    $display("FAIL sb_newPC_out: got %h, want %h", cur_npc, e.npc);
                end
            end
        end else begin
            n_checks++;
            if (cur_rd !== 32'h0 || cur_npc !== 32'h0) begin
                n_fail++;
                $display("FAIL bubble_zero: got rd=%h npc=%h, want 0/0", cur_rd, cur_npc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Wait to the sampling point of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    // Advance past the next rising edge and update the memory model.
    task automatic advance();
        logic        acc;
        logic [31:0] acc_addr;
        acc      = cur_req && imem_ready;
        acc_addr = cur_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = acc_addr;
            cnt       = mem_lat;
        end
        if (pend) begin
            if (cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr ^ KEY;
                pend        = 1'b0;
            end else begin
                cnt--;
            end
        end
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_t e;
        e.instr = addr ^ KEY;
        e.npc   = addr + 32'd4;
        exp_q.push_back(e);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        imem_ready = 1'b1;
        sample();
        n_checks++;
        if (cur_req !== 1'b0 || cur_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_req: got req=%b addr=%h, want 0/0", cur_req, cur_addr);
        end
        n_checks++;
        if (cur_valid !== 1'b0 || cur_rd !== 32'h0 || cur_npc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b rd=%h npc=%h, want 0", cur_valid, cur_rd, cur_npc);
        end
        advance();
        imem_ready = 1'b0;
        rst_a      = 1'b1;
    endtask

    task automatic test_sequence();
        mem_lat    = 1;
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp(32'(4 * i));
            sample();
            n_checks++;
            if (cur_req !== 1'b1 || cur_addr !== 32'(4 * i) || cur_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: got req=%b addr=%h v=%b, want 1/%h/0",
                         i, cur_req, cur_addr, cur_valid, 32'(4 * i));
            end
            advance();
            sample();
            n_checks++;
            if (cur_valid !== 1'b1 || cur_req !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_deliver%0d: got v=%b req=%b, want 1/0", i, cur_valid, cur_req);
            end
            advance();
        end
        imem_ready = 1'b0;
    endtask

    task automatic test_stall();
        // pc is 0xC here
        push_exp(32'hC);
        imem_ready = 1'b1;
        sample();
        n_checks++;
        if (cur_req !== 1'b1 || cur_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_fetch: got req=%b addr=%h, want 1/c", cur_req, cur_addr);
        end
        advance();
        imem_ready = 1'b0;
        stall      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            n_checks++;
            if (cur_valid !== 1'b0 || cur_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_bubble%0d: got v=%b req=%b, want 0/0", k, cur_valid, cur_req);
            end
            advance();
        end
        stall = 1'b0;
        sample();
        n_checks++;
        if (cur_valid !== 1'b1 || cur_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b req=%b, want 1/0", cur_valid, cur_req);
        end
        advance();
    endtask

    task automatic test_redirect_wait();
        // pc is 0x10 here
        mem_lat    = 2;
        imem_ready = 1'b1;
        sample();
        advance();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        sample();
        n_checks++;
        if (cur_req !== 1'b0 || cur_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdw_wait: got req=%b v=%b, want 0/0", cur_req, cur_valid);
        end
        advance();
        redirect = 1'b0;
        sample();
        n_checks++;
        if (cur_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdw_killed: got v=%b, want 0", cur_valid);
        end
        advance();
        mem_lat    = 1;
        imem_ready = 1'b1;
        push_exp(32'h100);
        sample();
        n_checks++;
        if (cur_req !== 1'b1 || cur_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL rdw_newaddr: got req=%b addr=%h, want 1/100", cur_req, cur_addr);
        end
        advance();
        imem_ready = 1'b0;
        sample();
        n_checks++;
        if (cur_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rdw_deliver: got v=%b, want 1", cur_valid);
        end
        advance();
    endtask

    task automatic test_redirect_fetch();
        // pc is 0x104 here
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        sample();
        n_checks++;
        if (cur_req !== 1'b1 || cur_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL rdf_before: got req=%b addr=%h, want 1/104", cur_req, cur_addr);
        end
        advance();
        imem_ready = 1'b1;  // redirect still high: accepted request gets killed
        sample();
        n_checks++;
        if (cur_req !== 1'b1 || cur_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL rdf_aligned: got req=%b addr=%h, want 1/200", cur_req, cur_addr);
        end
        advance();
        imem_ready = 1'b0;
        redirect   = 1'b0;
        sample();
        n_checks++;
        if (cur_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdf_killed: got v=%b, want 0", cur_valid);
        end
        advance();
        imem_ready = 1'b1;
        push_exp(32'h200);
        sample();
        n_checks++;
        if (cur_req !== 1'b1 || cur_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL rdf_refetch: got req=%b addr=%h, want 1/200", cur_req, cur_addr);
        end
        advance();
        imem_ready = 1'b0;
        sample();
        advance();
    endtask

    task automatic test_wrap();
        sel   = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b1;
        imem_ready = 1'b1;
        exp_q.push_back('{instr: 32'hFFFF_FFFC ^ KEY, npc: 32'h0});
        sample();
        n_checks++;
        if (cur_req !== 1'b1 || cur_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first: got req=%b addr=%h, want 1/fffffffc", cur_req, cur_addr);
        end
        advance();
        imem_ready = 1'b0;
        sample();
        n_checks++;
        if (cur_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_deliver: got v=%b, want 1", cur_valid);
        end
        advance();
        sample();
        n_checks++;
        if (cur_req !== 1'b1 || cur_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_next: got req=%b addr=%h, want 1/0", cur_req, cur_addr);
        end
        advance();
    endtask

    task automatic test_reset_mid_wait();
        sel        = 1'b0;
        rst_b      = 1'b0;
        rst_a      = 1'b1;
        mem_lat    = 3;
        imem_ready = 1'b1;
        sample();
        advance();
        imem_ready = 1'b0;
        sample();
        advance();
        rst_a = 1'b0;
        sample();
        n_checks++;
        if (cur_req !== 1'b0 || cur_addr !== 32'h0 || cur_valid !== 1'b0 ||
            cur_rd !== 32'h0 || cur_npc !== 32'h0) begin
            n_fail++;
            $display("FAIL rmw_in_reset: got req=%b addr=%h v=%b rd=%h npc=%h, want all 0",
                     cur_req, cur_addr, cur_valid, cur_rd, cur_npc);
        end
        advance();
        // stale response arrives this cycle, just as reset releases
        rst_a = 1'b1;
        sample();
        n_checks++;
        if (cur_valid !== 1'b0 || cur_req !== 1'b1 || cur_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rmw_stale: got v=%b req=%b addr=%h, want 0/1/0", cur_valid, cur_req, cur_addr);
        end
        mem_lat    = 1;
        imem_ready = 1'b1;
        push_exp(32'h0);
        advance();
        imem_ready = 1'b0;
        sample();
        n_checks++;
        if (cur_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_deliver: got v=%b, want 1", cur_valid);
        end
        advance();
    endtask

    initial begin
        rst_a       = 1'b0;
        rst_b       = 1'b0;
        sel         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_lat     = 1;
        pend        = 1'b0;
        pend_addr   = 32'h0;
        cnt         = 0;
        @(posedge clk);
        #1;

        test_reset();
        test_sequence();
        test_stall();
        test_redirect_wait();
        test_redirect_fetch();
        test_wrap();
        test_reset_mid_wait();

        sample();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
